decode_cycle: RTL and testbench

//  Decode stage, directly downstream of the fetch stage. Consumes the fetch outputs InstrD/PCD/PCPlus4D.

---
 rtl/decode_cycle.sv | 180 ++++++++++++++++++
 tb/tb_decode_cycle.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - decode stage: register file, control decode, load-use stall, D->E register
// Optional DECODE_PERF_CNT_EN adds non-bubble/bubble slot counters DecCntE/BubCntE.
module decode_cycle #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [32:0]       InstrD,
    input  logic [PC_W-1:0]   PCD,
    input  logic [PC_W-1:0]   PCPlus4D,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [3:0]        RdW,
    input  logic [DATA_W-1:0] ResultW,
    output logic              StallFD,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic              BranchE,
    output logic              JumpE,
    output logic              ALUSrcE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [3:0]        RdE,
    output logic [3:0]        Rs1E,
    output logic [3:0]        Rs2E,
    output logic [PC_W-1:0]   PCE,
    output logic [PC_W-1:0]   PCPlus4E,
    output logic              IllegalE
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       DecCntE,
    output logic [31:0]       BubCntE
`endif
);

    logic [4:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] rf [16];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm_ext;
    logic              wb_en;
    logic              illegal;
    logic              bubble;
    logic              reg_write;
    logic              mem_write;
    logic              result_src;
    logic              branch;
    logic              jump;
    logic              alu_src;
    logic [2:0]        alu_ctrl;

    assign op      = InstrD[32:28];
    assign rd      = InstrD[27:24];
    assign rs1     = InstrD[23:20];
    assign rs2     = InstrD[19:16];
    assign imm16   = InstrD[15:0];
    assign imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    assign wb_en   = RegWriteW && (RdW != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[RdW] <= ResultW;
        end
    end

    // Same-cycle writeback is forwarded so a write and read of one register never conflict.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 4'd0) rd1 = (wb_en && RdW == rs1) ? ResultW : rf[rs1];
        if (rs2 != 4'd0) rd2 = (wb_en && RdW == rs2) ? ResultW : rf[rs2];
    end

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        result_src = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = 3'b000;
        illegal    = 1'b0;
        case (op)
            5'h00: ;
            5'h01: reg_write = (rd != 4'd0);
            5'h02: begin reg_write = (rd != 4'd0); alu_ctrl = 3'b001; end
            5'h03: begin reg_write = (rd != 4'd0); alu_ctrl = 3'b010; end
            5'h04: begin reg_write = (rd != 4'd0); alu_ctrl = 3'b011; end
            5'h05: begin reg_write = (rd != 4'd0); alu_src = 1'b1; end
            5'h06: begin reg_write = (rd != 4'd0); alu_src = 1'b1; result_src = 1'b1; end
            5'h07: begin mem_write = 1'b1; alu_src = 1'b1; end
            5'h08: begin branch = 1'b1; alu_ctrl = 3'b001; end
            5'h09: jump = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Load in E whose destination feeds the instruction in D: hold D one cycle.
    assign StallFD = ResultSrcE && RegWriteE && (RdE != 4'd0) && ((RdE == rs1) || (RdE == rs2));
    assign bubble  = FlushE || StallFD || illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RdE         <= 4'd0;
            Rs1E        <= 4'd0;
            Rs2E        <= 4'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            IllegalE    <= 1'b0;
        end else begin
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            if (bubble) begin
                RegWriteE   <= 1'b0;
                MemWriteE   <= 1'b0;
                ResultSrcE  <= 1'b0;
                BranchE     <= 1'b0;
                JumpE       <= 1'b0;
                ALUSrcE     <= 1'b0;
                ALUControlE <= 3'b000;
                RD1E        <= '0;
                RD2E        <= '0;
                ImmExtE     <= '0;
                RdE         <= 4'd0;
                Rs1E        <= 4'd0;
                Rs2E        <= 4'd0;
                IllegalE    <= illegal && !FlushE && !StallFD;
            end else begin
                RegWriteE   <= reg_write;
                MemWriteE   <= mem_write;
                ResultSrcE  <= result_src;
                BranchE     <= branch;
                JumpE       <= jump;
                ALUSrcE     <= alu_src;
                ALUControlE <= alu_ctrl;
                RD1E        <= rd1;
                RD2E        <= rd2;
                ImmExtE     <= imm_ext;
                RdE         <= rd;
                Rs1E        <= rs1;
                Rs2E        <= rs2;
                IllegalE    <= 1'b0;
            end
        end
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DecCntE <= 32'd0;
            BubCntE <= 32'd0;
        end else if (bubble) begin
            BubCntE <= BubCntE + 32'd1;
        end else begin
            DecCntE <= DecCntE + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - self-checking bench for decode_cycle (model + directed vectors)
module tb_decode_cycle;

    typedef struct packed {
        logic        rw, mw, rs, br, jp, as;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  rd, rs1, rs2;
        logic [8:0]  pc, pc4;
        logic        ill;
    } e_t;

    typedef struct {
        logic [32:0] ins;
        logic        fl;
        logic        wbe;
        logic [3:0]  wbr;
        logic [31:0] wbd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] InstrD = '0;
    logic [8:0]  PCD = '0;
    logic [8:0]  PCPlus4D = '0;
    logic        FlushE = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [3:0]  RdW = '0;
    logic [31:0] ResultW = '0;
    logic        StallFD;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [3:0]  RdE, Rs1E, Rs2E;
    logic [8:0]  PCE, PCPlus4E;
    logic        IllegalE;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] DecCntE, BubCntE;
`endif

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;
    logic [8:0] pc = '0;

    e_t          exp_e;
    e_t          dut_e;
    logic [31:0] mreg [16];
    logic [31:0] mdec, mbub;

    decode_cycle #(.DATA_W(32), .PC_W(9)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallFD(StallFD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .IllegalE(IllegalE)
`ifdef DECODE_PERF_CNT_EN
        , .DecCntE(DecCntE), .BubCntE(BubCntE)
`endif
    );

    always #5 clk = ~clk;

    assign dut_e = {RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, ALUControlE,
                    RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E, IllegalE};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [32:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic logic [31:0] reg_val(input logic [3:0] r);
        if (r == 0) return 32'd0;
        if (RegWriteW && RdW == r) return ResultW;
        return mreg[r];
    endfunction

    function automatic logic model_stall(input e_t e, input logic [32:0] ins);
        return e.rs && e.rw && e.rd != 0 && (e.rd == ins[23:20] || e.rd == ins[19:16]);
    endfunction

    function automatic e_t model_next(output logic bub);
        e_t n;
        int op;
        n = '0;
        op = int'(InstrD[32:28]);
        n.pc  = PCD;
        n.pc4 = PCPlus4D;
        bub = 1'b1;
        if (FlushE || model_stall(exp_e, InstrD)) return n;
        if (op > 9) begin
            n.ill = 1'b1;
            return n;
        end
        bub = 1'b0;
        n.rd  = InstrD[27:24];
        n.rs1 = InstrD[23:20];
        n.rs2 = InstrD[19:16];
        n.rd1 = reg_val(n.rs1);
        n.rd2 = reg_val(n.rs2);
        n.imm = 32'($signed(InstrD[15:0]));
        n.rw  = (op >= 1 && op <= 6 && n.rd != 0);
        n.mw  = (op == 7);
        n.rs  = (op == 6);
        n.br  = (op == 8);
        n.jp  = (op == 9);
        n.as  = (op >= 5 && op <= 7);
        n.alu = (op == 2 || op == 8) ? 3'd1 : (op == 3) ? 3'd2 : (op == 4) ? 3'd3 : 3'd0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_e <= '0;
            mdec  <= '0;
            mbub  <= '0;
            for (int i = 0; i < 16; i++) mreg[i] <= '0;
        end else begin
            logic b;
            exp_e <= model_next(b);
            if (b) mbub <= mbub + 1;
            else   mdec <= mdec + 1;
            if (RegWriteW && RdW != 0) mreg[RdW] <= ResultW;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("e_slot", 256'(dut_e), 256'(exp_e));
            chk("stall", 256'(StallFD), 256'(model_stall(exp_e, InstrD)));
`ifdef DECODE_PERF_CNT_EN
            chk("dec_cnt", 256'(DecCntE), 256'(mdec));
            chk("bub_cnt", 256'(BubCntE), 256'(mbub));
`endif
        end
    end

    task automatic drive(input logic [32:0] ins, input logic fl, input logic wbe,
                         input logic [3:0] wbr, input logic [31:0] wbd);
        @(negedge clk);
        #1;
        InstrD = ins; FlushE = fl; RegWriteW = wbe; RdW = wbr; ResultW = wbd;
        PCD = pc; PCPlus4D = pc + 9'd1; pc = pc + 9'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [32:0] ins, input logic fl, input logic wbe,
                        input logic [3:0] wbr, input logic [31:0] wbd);
        drive(ins, fl, wbe, wbr, wbd);
        tick();
    endtask

    vec_t tbl [$];

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_regwrite", 256'(RegWriteE), 256'(0));
        chk("reset_pce", 256'(PCE), 256'(0));
        drive('0, 0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // ADDI r1,r0,#0xFFFF
        step(mk(5'h05, 4'd1, 4'd0, 4'd0, 16'hFFFF), 0, 0, 0, 0);
        chk("addi_regwrite", 256'(RegWriteE), 256'(1));
        chk("addi_alusrc", 256'(ALUSrcE), 256'(1));
        chk("addi_imm", 256'(ImmExtE), 256'(32'hFFFF_FFFF));
        chk("addi_rd", 256'(RdE), 256'(1));
        chk("addi_rd1", 256'(RD1E), 256'(0));

        // r3=5 then reset mid-run
        step(mk(5'h00, 4'd0, 4'd0, 4'd0, 16'h0), 0, 1, 4'd3, 32'd5);
        step(mk(5'h01, 4'd7, 4'd3, 4'd3, 16'h0), 0, 0, 0, 0);
        chk("pre_rst_r3", 256'(RD1E), 256'(5));
        rst = 1'b1;
        #1;
        chk("rst_regwrite", 256'(RegWriteE), 256'(0));
        chk("rst_rd1", 256'(RD1E), 256'(0));
        chk("rst_illegal", 256'(IllegalE), 256'(0));
        drive(mk(5'h01, 4'd4, 4'd3, 4'd3, 16'h0), 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_r3", 256'(RD1E), 256'(0));
        chk("post_rst_rd", 256'(RdE), 256'(4));

        // bypass of same-cycle writeback
        step(mk(5'h01, 4'd4, 4'd2, 4'd2, 16'h0), 0, 1, 4'd2, 32'h1234);
        chk("bypass_rd1", 256'(RD1E), 256'(32'h1234));
        chk("bypass_rd2", 256'(RD2E), 256'(32'h1234));

        // load-use stall
        step(mk(5'h06, 4'd5, 4'd1, 4'd0, 16'h0004), 0, 0, 0, 0);
        chk("load_resultsrc", 256'(ResultSrcE), 256'(1));
        drive(mk(5'h01, 4'd6, 4'd5, 4'd1, 16'h0), 0, 0, 0, 0);
        #1;
        chk("stall_high", 256'(StallFD), 256'(1));
        tick();
        chk("stall_bubble_rw", 256'(RegWriteE), 256'(0));
        chk("stall_bubble_rd", 256'(RdE), 256'(0));
        chk("stall_low", 256'(StallFD), 256'(0));
        step(mk(5'h01, 4'd6, 4'd5, 4'd1, 16'h0), 0, 0, 0, 0);
        chk("after_stall_rd", 256'(RdE), 256'(6));

        // illegal opcode with and without flush
        step(mk(5'h1F, 4'd0, 4'd0, 4'd0, 16'h0), 1, 0, 0, 0);
        chk("flush_illegal", 256'(IllegalE), 256'(0));
        step(mk(5'h1F, 4'd0, 4'd0, 4'd0, 16'h0), 0, 0, 0, 0);
        chk("illegal_flag", 256'(IllegalE), 256'(1));
        chk("illegal_rw", 256'(RegWriteE), 256'(0));
        step(mk(5'h00, 4'd0, 4'd0, 4'd0, 16'h0), 0, 0, 0, 0);
        chk("illegal_clear", 256'(IllegalE), 256'(0));

        // r0 ignores writes
        step(mk(5'h01, 4'd1, 4'd0, 4'd0, 16'h0), 0, 1, 4'd0, 32'hDEAD);
        chk("r0_rd1", 256'(RD1E), 256'(0));
        step(mk(5'h01, 4'd1, 4'd0, 4'd0, 16'h0), 0, 0, 0, 0);
        chk("r0_rd2", 256'(RD2E), 256'(0));

        // remaining opcodes and mixed traffic, checked by the model
        tbl.push_back('{mk(5'h00, 4'd0, 4'd0, 4'd0, 16'h0),    0, 1, 4'd8, 32'hA5A5_0001});
        tbl.push_back('{mk(5'h02, 4'd9, 4'd8, 4'd2, 16'h8000), 0, 1, 4'd9, 32'h0000_00FF});
        tbl.push_back('{mk(5'h03, 4'd10, 4'd9, 4'd8, 16'h7FFF), 0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h04, 4'd11, 4'd2, 4'd9, 16'h0),   0, 1, 4'd15, 32'hCAFE_F00D});
        tbl.push_back('{mk(5'h07, 4'd0, 4'd15, 4'd8, 16'hFFF0), 0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h08, 4'd0, 4'd15, 4'd9, 16'h0010), 0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h09, 4'd0, 4'd0, 4'd0, 16'h0020), 0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h06, 4'd0, 4'd8, 4'd0, 16'h0),   0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h01, 4'd1, 4'd0, 4'd0, 16'h0),   0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h06, 4'd12, 4'd8, 4'd0, 16'h2),  0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h02, 4'd13, 4'd2, 4'd12, 16'h0), 0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h02, 4'd13, 4'd2, 4'd12, 16'h0), 0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h05, 4'd14, 4'd15, 4'd0, 16'h1), 1, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h0A, 4'd1, 4'd1, 4'd1, 16'h1),   0, 0, 4'd0, 32'h0});
        tbl.push_back('{mk(5'h05, 4'd14, 4'd15, 4'd0, 16'h1), 0, 1, 4'd15, 32'h1});
        foreach (tbl[i]) step(tbl[i].ins, tbl[i].fl, tbl[i].wbe, tbl[i].wbr, tbl[i].wbd);
        chk("final_imm", 256'(ImmExtE), 256'(32'h1));
        chk("final_rd1", 256'(RD1E), 256'(32'h1));

        drive('0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
